// File: rtl/core_pkg.sv
// Shared types for the instruction fetch path: buffered fetch entries and prefetcher states.
package core_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        PF_RUN      = 1'b0,
        PF_WAIT_GNT = 1'b1
    } pf_state_e;

    function automatic logic [31:0] word_addr(input logic [29:0] w);
        return {w, 2'b00};
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with synchronous flush; push into a full FIFO is accepted only alongside a pop.
module fifo_sync #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetcher: issues OBI word fetches under a credit limit, buffers
// responses with their addresses, and drops responses that belong to a flushed stream.
module prefetch_buffer
    import core_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [29:0] boot_addr_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        busy_o,
    output logic        insn_obi_req_o,
    input  logic        insn_obi_gnt_i,
    output logic [31:0] insn_obi_addr_o,
    output logic        insn_obi_we_o,
    output logic [3:0]  insn_obi_be_o,
    output logic [31:0] insn_obi_wdata_o,
    input  logic        insn_obi_rvalid_i,
    output logic        insn_obi_rready_o,
    input  logic [31:0] insn_obi_rdata_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(DEPTH);

    pf_state_e     r_state;
    pf_state_e     w_state_next;
    logic [29:0]   r_fetch_addr;
    logic [29:0]   r_pend_addr;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;
    logic [29:0]   r_aq [DEPTH];
    logic [QW-1:0] r_aq_wr;
    logic [QW-1:0] r_aq_rd;

    logic [29:0]   w_fetch_next;
    logic [29:0]   w_pend_next;
    logic [OW-1:0] w_out_next;
    logic [OW-1:0] w_disc_next;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;
    logic          w_credit;
    logic          w_req;
    logic          w_grant;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_unused_bits;

    // Discarded transactions still occupy the bus credit but will never land in the FIFO.
    assign w_credit = ((int'(w_fifo_count) + int'(r_outstanding) - int'(r_discard)) < DEPTH)
                   && (int'(r_outstanding) < MAX_OUTSTANDING);
    assign w_req    = rst_n_i && ((r_state == PF_WAIT_GNT) || w_credit);
    assign w_grant  = w_req && insn_obi_gnt_i;
    assign w_drop   = insn_obi_rvalid_i && (r_discard != '0);
    assign w_push   = insn_obi_rvalid_i && (r_discard == '0) && !branch_i;
    assign w_pop    = !w_fifo_empty && instr_ready_i && !branch_i;
    assign w_out_next = r_outstanding + OW'(w_grant) - OW'(insn_obi_rvalid_i);

    assign w_push_entry.addr  = word_addr(r_aq[r_aq_rd]);
    assign w_push_entry.instr = insn_obi_rdata_i;

    fifo_sync #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_flush (branch_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= PF_RUN;
            r_fetch_addr  <= boot_addr_i;
            r_pend_addr   <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_aq_wr       <= '0;
            r_aq_rd       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_addr  <= w_fetch_next;
            r_pend_addr   <= w_pend_next;
            r_outstanding <= w_out_next;
            r_discard     <= w_disc_next;
            if (w_grant)           r_aq_wr <= r_aq_wr + 1'b1;
            if (insn_obi_rvalid_i) r_aq_rd <= r_aq_rd + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_grant) r_aq[r_aq_wr] <= r_fetch_addr;
    end

    // A branch seen while a request waits for grant keeps the bus stable and parks the target;
    // the held request is then counted as discarded when it is finally granted.
    always_comb begin
        w_state_next = r_state;
        w_fetch_next = r_fetch_addr;
        w_pend_next  = r_pend_addr;
        w_disc_next  = r_discard;
        if (branch_i) begin
            w_disc_next = w_out_next;
            if (w_req && !insn_obi_gnt_i) begin
                w_state_next = PF_WAIT_GNT;
                w_pend_next  = branch_addr_i[31:2];
            end else begin
                w_state_next = PF_RUN;
                w_fetch_next = branch_addr_i[31:2];
            end
        end else begin
            w_disc_next = r_discard - OW'(w_drop) + OW'(w_grant && (r_state == PF_WAIT_GNT));
            if (w_grant) begin
                if (r_state == PF_WAIT_GNT) begin
                    w_state_next = PF_RUN;
                    w_fetch_next = r_pend_addr;
                end else begin
                    w_fetch_next = r_fetch_addr + 30'd1;
                end
            end
        end
    end

    assign instr_valid_o     = !w_fifo_empty;
    assign instr_rdata_o     = w_fifo_empty ? 32'h0 : w_head.instr;
    assign instr_addr_o      = w_fifo_empty ? 32'h0 : w_head.addr;
    assign busy_o            = (r_outstanding != '0) || w_req;
    assign insn_obi_req_o    = w_req;
    assign insn_obi_addr_o   = word_addr(r_fetch_addr);
    assign insn_obi_we_o     = 1'b0;
    assign insn_obi_be_o     = 4'hF;
    assign insn_obi_wdata_o  = 32'h0;
    assign insn_obi_rready_o = 1'b1;
    assign w_unused_bits     = ^branch_addr_i[1:0];

`ifndef SYNTHESIS
    a_outstanding_max: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        int'(r_outstanding) <= MAX_OUTSTANDING);
    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        insn_obi_rvalid_i |-> (r_outstanding != '0));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (w_req && !insn_obi_gnt_i) |=> (w_req && $stable(insn_obi_addr_o)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        w_push |-> (!w_fifo_full || w_pop));
`endif

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer: a queue-based reference model checked every cycle,
// plus hand-derived expectations for grant order, latency, flushing and address wrap.
module tb_prefetch_buffer;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [29:0] boot_addr_i = '0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        busy_o;
    logic        insn_obi_req_o;
    logic        insn_obi_gnt_i = 1'b0;
    logic [31:0] insn_obi_addr_o;
    logic        insn_obi_we_o;
    logic [3:0]  insn_obi_be_o;
    logic [31:0] insn_obi_wdata_o;
    logic        insn_obi_rvalid_i = 1'b0;
    logic        insn_obi_rready_o;
    logic [31:0] insn_obi_rdata_i = '0;

    prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .boot_addr_i       (boot_addr_i),
        .branch_i          (branch_i),
        .branch_addr_i     (branch_addr_i),
        .instr_valid_o     (instr_valid_o),
        .instr_ready_i     (instr_ready_i),
        .instr_rdata_o     (instr_rdata_o),
        .instr_addr_o      (instr_addr_o),
        .busy_o            (busy_o),
        .insn_obi_req_o    (insn_obi_req_o),
        .insn_obi_gnt_i    (insn_obi_gnt_i),
        .insn_obi_addr_o   (insn_obi_addr_o),
        .insn_obi_we_o     (insn_obi_we_o),
        .insn_obi_be_o     (insn_obi_be_o),
        .insn_obi_wdata_o  (insn_obi_wdata_o),
        .insn_obi_rvalid_i (insn_obi_rvalid_i),
        .insn_obi_rready_o (insn_obi_rready_o),
        .insn_obi_rdata_i  (insn_obi_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; bit drop; } flight_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } entry_t;
    typedef struct { logic [31:0] addr; int due; } slave_t;

    flight_t     mFlight[$];
    entry_t      mFifo[$];
    logic [31:0] mFetch;
    logic [31:0] mPend;
    bit          mHeld;
    slave_t      slaveQ[$];
    logic [31:0] grantLog[$];
    logic [31:0] acceptLog[$];
    int          cycleNo = 0;
    int          latency = 1;
    bit          gntEnable = 1'b0;
    bit          readyEnable = 1'b0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] rdataOf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    // Fetch is allowed while the buffered plus live (not-to-be-dropped) words leave room.
    function automatic bit modelReq();
        int live = 0;
        if (mHeld) return 1'b1;
        foreach (mFlight[i]) if (!mFlight[i].drop) live++;
        return ((mFifo.size() + live) < DEPTH) && (mFlight.size() < MAXO);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance both.
    task automatic applyStimulus(input bit br, input logic [31:0] brAddr);
        bit          expReq;
        bit          g;
        bit          rv;
        logic [31:0] rd;
        flight_t     f;
        expReq            = modelReq();
        branch_i          = br;
        branch_addr_i     = brAddr;
        insn_obi_gnt_i    = gntEnable;
        instr_ready_i     = readyEnable;
        rv                = (slaveQ.size() > 0) && (slaveQ[0].due <= cycleNo);
        rd                = rv ? rdataOf(slaveQ[0].addr) : 32'h0;
        insn_obi_rvalid_i = rv;
        insn_obi_rdata_i  = rd;
        #1;
        checkOutput("req_o", 32'(insn_obi_req_o), 32'(expReq));
        if (expReq) checkOutput("obi_addr", insn_obi_addr_o, mFetch);
        checkOutput("instr_valid", 32'(instr_valid_o), 32'(mFifo.size() != 0));
        if (mFifo.size() != 0) begin
            checkOutput("instr_addr", instr_addr_o, mFifo[0].addr);
            checkOutput("instr_rdata", instr_rdata_o, mFifo[0].data);
        end
        checkOutput("busy", 32'(busy_o), 32'((mFlight.size() != 0) || expReq));

        if (instr_valid_o && readyEnable && !br) acceptLog.push_back(instr_addr_o);
        if (insn_obi_req_o && gntEnable) begin
            grantLog.push_back(insn_obi_addr_o);
            slaveQ.push_back('{addr: insn_obi_addr_o, due: cycleNo + latency});
        end
        if (rv) void'(slaveQ.pop_front());

        g = expReq && gntEnable;
        if (!br && readyEnable && mFifo.size() != 0) void'(mFifo.pop_front());
        if (rv && mFlight.size() != 0) begin
            f = mFlight.pop_front();
            if (!f.drop && !br) mFifo.push_back('{addr: f.addr, data: rd});
        end
        if (g) mFlight.push_back('{addr: mFetch, drop: (mHeld || br)});
        if (br) begin
            mFifo.delete();
            foreach (mFlight[i]) mFlight[i].drop = 1'b1;
            if (expReq && !gntEnable) begin
                mHeld = 1'b1;
                mPend = {brAddr[31:2], 2'b00};
            end else begin
                mHeld  = 1'b0;
                mFetch = {brAddr[31:2], 2'b00};
            end
        end else if (g) begin
            if (mHeld) begin
                mHeld  = 1'b0;
                mFetch = mPend;
            end else begin
                mFetch = mFetch + 32'd4;
            end
        end
        @(posedge clk_i);
        cycleNo++;
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        repeat (n) applyStimulus(1'b0, 32'h0);
    endtask

    task automatic doReset(input logic [29:0] boot);
        rst_n_i           = 1'b0;
        boot_addr_i       = boot;
        branch_i          = 1'b0;
        branch_addr_i     = '0;
        insn_obi_gnt_i    = 1'b0;
        insn_obi_rvalid_i = 1'b0;
        insn_obi_rdata_i  = '0;
        instr_ready_i     = 1'b0;
        slaveQ.delete();
        grantLog.delete();
        acceptLog.delete();
        mFlight.delete();
        mFifo.delete();
        mHeld  = 1'b0;
        mPend  = '0;
        mFetch = {boot, 2'b00};
        repeat (2) @(negedge clk_i);
        checkOutput("rst_req", 32'(insn_obi_req_o), 32'h0);
        checkOutput("rst_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("rst_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_rdata", instr_rdata_o, 32'h0);
        checkOutput("rst_iaddr", instr_addr_o, 32'h0);
        rst_n_i = 1'b1;
        cycleNo = 0;
    endtask

    task automatic drain();
        int budget = 40;
        gntEnable   = 1'b0;
        readyEnable = 1'b1;
        while (slaveQ.size() != 0 && budget > 0) begin
            applyStimulus(1'b0, 32'h0);
            budget--;
        end
        checkOutput("drain_pending", 32'(slaveQ.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Sequential fetch from boot address, one-cycle response latency.
        doReset(30'h20);
        checkOutput("tie_we", 32'(insn_obi_we_o), 32'h0);
        checkOutput("tie_be", 32'(insn_obi_be_o), 32'hF);
        checkOutput("tie_wdata", insn_obi_wdata_o, 32'h0);
        checkOutput("tie_rready", 32'(insn_obi_rready_o), 32'h1);
        gntEnable = 1'b1; readyEnable = 1'b1; latency = 1;
        run(2);
        checkOutput("t1_valid_lat", 32'(instr_valid_o), 32'h1);
        checkOutput("t1_first_iaddr", instr_addr_o, 32'h80);
        run(6);
        for (int i = 0; i < 4; i++) checkOutput("t1_grant_addr", grantLog[i], 32'h80 + 32'(4 * i));

        // Stalled consumer: credit caps grants at DEPTH, one pop buys one more.
        drain();
        doReset(30'h20);
        gntEnable = 1'b1; readyEnable = 1'b0; latency = 1;
        run(10);
        checkOutput("t2_grants_full", 32'(grantLog.size()), 32'd4);
        checkOutput("t2_req_stopped", 32'(insn_obi_req_o), 32'h0);
        readyEnable = 1'b1;
        run(1);
        readyEnable = 1'b0;
        run(6);
        checkOutput("t2_grants_after_pop", 32'(grantLog.size()), 32'd5);
        checkOutput("t2_new_addr", grantLog[4], 32'h90);
        checkOutput("t2_req_stopped2", 32'(insn_obi_req_o), 32'h0);

        // Slow memory: outstanding limit stalls requests until the first response.
        drain();
        doReset(30'h40);
        gntEnable = 1'b1; readyEnable = 1'b1; latency = 5;
        run(3);
        checkOutput("t3_grants", 32'(grantLog.size()), 32'd2);
        checkOutput("t3_req_low", 32'(insn_obi_req_o), 32'h0);
        run(3);
        checkOutput("t3_grants_held", 32'(grantLog.size()), 32'd2);
        checkOutput("t3_req_resume", 32'(insn_obi_req_o), 32'h1);

        // Branch with two responses in flight: both dropped, target fetched aligned.
        drain();
        doReset(30'h40);
        gntEnable = 1'b1; readyEnable = 1'b1; latency = 5;
        run(2);
        applyStimulus(1'b1, 32'h0000_1003);
        checkOutput("t4_valid_after_br", 32'(instr_valid_o), 32'h0);
        run(20);
        checkOutput("t4_next_req", grantLog[2], 32'h1000);
        checkOutput("t4_first_accept", acceptLog[0], 32'h1000);

        // Branches while a request waits for grant: bus holds, last target wins.
        drain();
        doReset(30'h100);
        gntEnable = 1'b0; readyEnable = 1'b1; latency = 1;
        applyStimulus(1'b1, 32'h0000_2000);
        checkOutput("t5_req_held", 32'(insn_obi_req_o), 32'h1);
        checkOutput("t5_addr_held", insn_obi_addr_o, 32'h400);
        applyStimulus(1'b1, 32'h0000_2400);
        run(1);
        checkOutput("t5_addr_held2", insn_obi_addr_o, 32'h400);
        gntEnable = 1'b1;
        run(10);
        checkOutput("t5_grant_old", grantLog[0], 32'h400);
        checkOutput("t5_grant_target", grantLog[1], 32'h2400);
        checkOutput("t5_first_accept", acceptLog[0], 32'h2400);

        // Branch coinciding with pop, push and grant.
        drain();
        doReset(30'h20);
        gntEnable = 1'b1; readyEnable = 1'b1; latency = 1;
        run(4);
        checkOutput("t6_valid_pre", 32'(instr_valid_o), 32'h1);
        checkOutput("t6_req_pre", 32'(insn_obi_req_o), 32'h1);
        checkOutput("t6_head_pre", instr_addr_o, 32'h88);
        applyStimulus(1'b1, 32'h0000_3000);
        checkOutput("t6_flushed", 32'(instr_valid_o), 32'h0);
        run(10);
        checkOutput("t6_grant_at_br", grantLog[4], 32'h90);
        checkOutput("t6_grant_target", grantLog[5], 32'h3000);
        checkOutput("t6_accept_count_pre", acceptLog[1], 32'h84);
        checkOutput("t6_first_after_br", acceptLog[2], 32'h3000);

        // Fetch address wraps from the top of the address space.
        drain();
        doReset(30'h3FFF_FFFF);
        gntEnable = 1'b1; readyEnable = 1'b1; latency = 1;
        run(5);
        checkOutput("t7_grant_top", grantLog[0], 32'hFFFF_FFFC);
        checkOutput("t7_grant_wrap", grantLog[1], 32'h0);
        checkOutput("t7_accept_top", acceptLog[0], 32'hFFFF_FFFC);
        checkOutput("t7_accept_wrap", acceptLog[1], 32'h0);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
